edge_event_fifo: RTL and testbench

Downstream consumer of the 4-bit positive-edge detector. Samples the detector's `eddect` pulse vector every clock, tags each non-zero vector with a free-running timestamp, and buffers the tagged events in a small FIFO. A valid/ready interface presents the events to a slower reader. Overflow is flagged and counted rather than silently lost.

---
 rtl/edge_event_fifo.sv | 116 +++++++++++
 tb/tb_edge_event_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_fifo.sv
// edge_event_fifo: timestamps non-zero edge pulse vectors and buffers them
// in a circular FIFO with a show-ahead valid/ready read port. Overflow is
// sticky and dropped events are counted (saturating).
module edge_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                eddect,
    output logic [TS_W+3:0]           out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                drop_cnt,
    input  logic                      clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = TS_W + 4;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   level_q, level_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [EW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic            push_req, pop, full, push_ok, drop;
    logic [EW-1:0]   entry, head_d;
    logic [AW-1:0]   rd_idx_d;

    // Next-state: pointers, level, show-ahead head, overflow bookkeeping.
    always_comb begin
        push_req = |eddect;
        pop      = out_valid_q & out_ready;
        // Same index with differing wrap bits means full.
        full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, AW'(0)};
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        entry    = {ts_q, eddect};

        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + PW'(push_ok) - PW'(pop);
        ts_d     = ts_q + TS_W'(1);

        // Bypass the new entry when it lands exactly at the next head slot.
        rd_idx_d = rd_ptr_d[AW-1:0];
        if (push_ok && (wr_ptr_q[AW-1:0] == rd_idx_d)) begin
            head_d = entry;
        end else begin
            head_d = mem_q[rd_idx_d];
        end
        out_valid_d = (level_d != '0);
        out_data_d  = out_valid_d ? head_d : out_data_q;

        // A drop in the same cycle as a clear wins.
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ts_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ts_q        <= ts_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Entry storage; no push is taken in a reset cycle.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= entry;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_edge_event_fifo.sv
// Bench for edge_event_fifo: queue-based reference model, scoreboard
// monitor on the read handshake, directed scenarios plus random traffic.
module tb_edge_event_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  eddect = 4'd0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_ovf = 1'b0;

    always #5 clk = ~clk;

    edge_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .eddect    (eddect),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    logic [11:0] m_ts   = '0;
    bit          m_ovf  = 1'b0;
    int          m_drop = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_edge(input bit r, input logic [3:0] e, input bit rdy, input bit c);
        bit dropped;
        dropped = 1'b0;
        if (r) begin
            mq.delete();
            sb.delete();
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (e != 4'd0) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({m_ts, e});
                    sb.push_back({m_ts, e});
                end else begin
                    dropped = 1'b1;
                end
            end
            if (c) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (dropped) begin
                m_ovf  = 1'b1;
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
            m_ts = m_ts + 12'd1;
        end
    endtask

    // Drive one cycle; called just after a rising edge.
    task automatic step(input bit r, input logic [3:0] e, input bit rdy, input bit c);
        rst       = r;
        eddect    = e;
        out_ready = rdy;
        clr_ovf   = c;
        @(posedge clk);
        model_edge(r, e, rdy, c);
        #1;
    endtask

    // Monitor: status vs model every cycle, head data vs scoreboard on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", int'(out_valid), int'(mq.size() > 0));
            chk("level", int'(level), mq.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("drop_cnt", int'(drop_cnt), m_drop);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("pop_data", int'(out_data), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        logic [11:0] t0;

        // 1. Reset held with events present
        @(posedge clk); #1;
        step(1'b1, 4'hF, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 4'hF, 1'b0, 1'b0);
        chk("t1_valid", int'(out_valid), 0);
        chk("t1_level", int'(level), 0);
        chk("t1_ovf", int'(overflow), 0);
        chk("t1_drop", int'(drop_cnt), 0);

        // 2. Single event at ts=3
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'b0101, 1'b0, 1'b0);
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_data", int'(out_data), 16'h0035);
        chk("t2_level", int'(level), 1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t2_pop_valid", int'(out_valid), 0);
        chk("t2_pop_level", int'(level), 0);

        // 3. Fill and overflow, drain in order, clear
        t0 = m_ts;
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0001, 1'b0, 1'b0);
        chk("t3_level", int'(level), 8);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_drop", int'(drop_cnt), 2);
        for (int i = 0; i < 8; i++) begin
            chk("t3_ts", int'(out_data[15:4]), int'(12'(t0 + 12'(i))));
            step(1'b0, 4'h0, 1'b1, 1'b0);
        end
        chk("t3_empty", int'(out_valid), 0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t3_clr_ovf", int'(overflow), 0);
        chk("t3_clr_drop", int'(drop_cnt), 0);

        // 4. Push and pop while full
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0010, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 1'b1, 1'b0);
        chk("t4_level", int'(level), 8);
        chk("t4_ovf", int'(overflow), 0);
        chk("t4_drop", int'(drop_cnt), 0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t4_last_mask", int'(out_data[3:0]), 4'b1000);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // 6. Reset mid-operation with level 5 and overflow set
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t6_pre_level", int'(level), 5);
        chk("t6_pre_ovf", int'(overflow), 1);
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("t6_level", int'(level), 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_ovf", int'(overflow), 0);
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        chk("t6_ts_restart", int'(out_data), 16'h0001);
        chk("t6_level1", int'(level), 1);

        // 5. Timestamp wrap 4095 -> 0
        step(1'b1, 4'h0, 1'b0, 1'b0);
        while (m_ts != 12'hFFF) step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 1'b0, 1'b0);
        chk("t5_head_fff", int'(out_data), 16'hFFF1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t5_head_000", int'(out_data), 16'h0002);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] e;
            bit rdy, c, r;
            e   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 24) == 0);
            r   = ($urandom_range(0, 149) == 0);
            step(r, e, rdy, c);
        end

        // Drain the remainder
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("final_empty", int'(out_valid), 0);
        chk("final_sb_empty", sb.size(), 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
